// File: rtl/mbc_control_sequencer.sv
// rtl/mbc_control_sequencer.sv - timing/control sequencer for the basic-computer datapath
// Optional interrupt cycle and I/O instructions: MBC_INTERRUPT_EN
module mbc_control_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int SC_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] ir,
  input  logic              dr_zero,
  input  logic              ac_msb,
  input  logic              ac_zero,
  input  logic              e_flag,
  input  logic              fgi,
  input  logic              fgo,
  output logic [2:0]        bus_sel,
  output logic [2:0]        ar_ctl,
  output logic [2:0]        pc_ctl,
  output logic [2:0]        ac_ctl,
  output logic [1:0]        dr_ctl,
  output logic              ir_ld,
  output logic              tr_ld,
  output logic [2:0]        alu_op,
  output logic [1:0]        e_ctl,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [SC_W-1:0]   sc,
  output logic              halted
);

  typedef enum logic [SC_W-1:0] {
    T0 = SC_W'(0), T1 = SC_W'(1), T2 = SC_W'(2), T3 = SC_W'(3),
    T4 = SC_W'(4), T5 = SC_W'(5), T6 = SC_W'(6), T7 = SC_W'(7)
  } state_t;

  state_t                        state, state_nxt;
  logic                          i_reg;
  logic                          sc_clr, halt_set;
  logic                          run, act;
  logic [DATA_W-2-ADDR_W:0]      opcode;
  logic [ADDR_W-1:0]             b;

  assign opcode = ir[DATA_W-2:ADDR_W];
  assign b      = ir[ADDR_W-1:0];
  assign run    = en & ~halted;
  // Strobes are forced low while reset is held, not just after the first edge.
  assign act    = run & reset;
  assign sc     = state;

`ifdef MBC_INTERRUPT_EN
  logic ien, r, ien_set, ien_clr, r_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien <= 1'b0;
      r   <= 1'b0;
    end else if (run) begin
      if (ien_set)
        ien <= 1'b1;
      else if (ien_clr)
        ien <= 1'b0;
      if (r_clr)
        r <= 1'b0;
      else if (ien && (fgi || fgo) && !(state inside {T0, T1, T2}))
        r <= 1'b1;
    end
  end
`else
  logic unused_io;
  assign unused_io = fgi | fgo;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= T0;
      halted <= 1'b0;
      i_reg  <= 1'b0;
    end else if (run) begin
      state <= state_nxt;
      if (halt_set)
        halted <= 1'b1;
      if (state == T2)
        i_reg <= ir[DATA_W-1];
    end
  end

  always_comb begin
    if (sc_clr || state == T7)
      state_nxt = T0;
    else
      state_nxt = state_t'(state + 1'b1);
  end

  always_comb begin
    bus_sel  = 3'd0;
    ar_ctl   = 3'b000;
    pc_ctl   = 3'b000;
    ac_ctl   = 3'b000;
    dr_ctl   = 2'b00;
    ir_ld    = 1'b0;
    tr_ld    = 1'b0;
    alu_op   = 3'd0;
    e_ctl    = 2'b00;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    sc_clr   = 1'b0;
    halt_set = 1'b0;
`ifdef MBC_INTERRUPT_EN
    ien_set  = 1'b0;
    ien_clr  = 1'b0;
    r_clr    = 1'b0;
`endif
    if (act) begin
`ifdef MBC_INTERRUPT_EN
      // Interrupt cycle replaces the fetch: save PC in M[0], continue at address 1.
      if (r && (state inside {T0, T1, T2})) begin
        case (state)
          T0: begin bus_sel = 3'd2; tr_ld = 1'b1; ar_ctl = 3'b100; end
          T1: begin bus_sel = 3'd6; mem_wr = 1'b1; pc_ctl = 3'b100; end
          default: begin pc_ctl = 3'b010; ien_clr = 1'b1; r_clr = 1'b1; sc_clr = 1'b1; end
        endcase
      end else
`endif
      begin
        case (state)
          T0: begin bus_sel = 3'd2; ar_ctl = 3'b001; end
          T1: begin bus_sel = 3'd7; mem_rd = 1'b1; ir_ld = 1'b1; pc_ctl = 3'b010; end
          T2: begin bus_sel = 3'd5; ar_ctl = 3'b001; end
          T3: begin
            if (opcode == 3'd7) begin
              sc_clr = 1'b1;
              if (!i_reg) begin
                ac_ctl[2] = b[11];
                e_ctl[0]  = b[10];
                e_ctl[1]  = b[8];
                ac_ctl[1] = b[5];
                ac_ctl[0] = b[9] | b[7] | b[6];
                if (b[9])      alu_op = 3'd3;
                else if (b[7]) alu_op = 3'd4;
                else if (b[6]) alu_op = 3'd5;
                pc_ctl[1] = (b[4] & ~ac_msb) | (b[3] & ac_msb) |
                            (b[2] & ac_zero) | (b[1] & ~e_flag);
                halt_set  = b[0];
              end
`ifdef MBC_INTERRUPT_EN
              else begin
                if (b[11]) begin ac_ctl[0] = 1'b1; alu_op = 3'd6; end
                if (b[10]) bus_sel = 3'd4;
                pc_ctl[1] = (b[9] & fgi) | (b[8] & fgo);
                ien_set   = b[7];
                ien_clr   = b[6];
              end
`endif
            end else if (i_reg) begin
              bus_sel = 3'd7; mem_rd = 1'b1; ar_ctl = 3'b001;
            end
          end
          T4: begin
            case (opcode)
              3'd0, 3'd1, 3'd2, 3'd6: begin bus_sel = 3'd7; mem_rd = 1'b1; dr_ctl = 2'b01; end
              3'd3: begin bus_sel = 3'd4; mem_wr = 1'b1; sc_clr = 1'b1; end
              3'd4: begin bus_sel = 3'd1; pc_ctl = 3'b001; sc_clr = 1'b1; end
              3'd5: begin bus_sel = 3'd2; mem_wr = 1'b1; ar_ctl = 3'b010; end
              default: sc_clr = 1'b1;
            endcase
          end
          T5: begin
            case (opcode)
              3'd0: begin ac_ctl = 3'b001; alu_op = 3'd1; sc_clr = 1'b1; end
              3'd1: begin ac_ctl = 3'b001; alu_op = 3'd2; sc_clr = 1'b1; end
              3'd2: begin ac_ctl = 3'b001; alu_op = 3'd0; sc_clr = 1'b1; end
              3'd5: begin bus_sel = 3'd1; pc_ctl = 3'b001; sc_clr = 1'b1; end
              3'd6: dr_ctl = 2'b10;
              default: sc_clr = 1'b1;
            endcase
          end
          T6: begin
            sc_clr = 1'b1;
            if (opcode == 3'd6) begin
              bus_sel   = 3'd3;
              mem_wr    = 1'b1;
              pc_ctl[1] = dr_zero;
            end
          end
          default: sc_clr = 1'b1;
        endcase
      end
    end
  end

endmodule
